keypad_matrix_scan: RTL and testbench

- Active side of the 12-button keypad interface: drives the 4 column strobes of a 4x3 matrix keypad and samples the 3 row returns.
- Debounces the result and emits a key code plus single-cycle press and release strobes.
- Sits between the keypad pins and the game logic. Its key_code uses the 1..12 button numbering of b1..b12, so downstream turn and push logic consume it unchanged.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/key_debounce.sv | 116 +++++++++++
 rtl/keypad_matrix_scan.sv | 121 ++++++++++++
 tb/tb_keypad_matrix_scan.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : keypad_pkg                                             |
// | Description : Shared constants, FSM state type and key numbering for |
// |               the 4x3 matrix keypad scanner.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package keypad_pkg;

  localparam logic [3:0] KEY_NONE = 4'd0;
  localparam int         NUM_COLS = 4;
  localparam int         NUM_ROWS = 3;

  // Frame-result debounce states; S_HELD is S_IDLE with a nonzero stable key.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2
  } deb_state_t;

  // Button number b1..b12 for a column/row crossing.
  function automatic logic [3:0] key_code_of(input logic [1:0] col, input logic [1:0] row);
    return ({2'b00, col} * 4'd3) + {2'b00, row} + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : key_debounce                                           |
// | Description : Accepts one lowest-key result per scan frame, requires |
// |               DEBOUNCE_SCANS identical differing frames before the   |
// |               stable key changes, and emits press/release strobes.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_valid,
  input  logic [3:0] frame_result,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release
);

  localparam int                 MATCH_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(DEBOUNCE_SCANS);
  localparam logic [MATCH_W-1:0] MATCH_ONE    = MATCH_W'(1);

  deb_state_t         r_state;
  deb_state_t         w_state_nxt;
  deb_state_t         w_stable_state;
  logic [3:0]         r_candidate;
  logic [3:0]         w_candidate_nxt;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [MATCH_W-1:0] w_match_inc;
  logic [3:0]         r_key_code;
  logic [3:0]         w_key_code_nxt;
  logic               r_key_valid;
  logic               w_key_valid_nxt;
  logic               r_key_release;
  logic               w_key_release_nxt;

  // State, candidate, match count and the registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_candidate   <= KEY_NONE;
      r_match       <= '0;
      r_key_code    <= KEY_NONE;
      r_key_valid   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_candidate   <= w_candidate_nxt;
      r_match       <= w_match_nxt;
      r_key_code    <= w_key_code_nxt;
      r_key_valid   <= w_key_valid_nxt;
      r_key_release <= w_key_release_nxt;
    end
  end

  // Next-state: evaluated only at frame end; a commit fires when the
  // consecutive-match count reaches the target (immediately when it is 1).
  always_comb begin
    w_state_nxt       = r_state;
    w_candidate_nxt   = r_candidate;
    w_match_nxt       = r_match;
    w_key_code_nxt    = r_key_code;
    w_key_valid_nxt   = 1'b0;
    w_key_release_nxt = 1'b0;
    w_stable_state    = (r_key_code == KEY_NONE) ? S_IDLE : S_HELD;
    w_match_inc       = (r_match == MATCH_TARGET) ? r_match : r_match + MATCH_ONE;

    if (frame_valid) begin
      case (r_state)
        S_IDLE, S_HELD: begin
          if (frame_result != r_key_code) begin
            w_candidate_nxt = frame_result;
            w_match_nxt     = MATCH_ONE;
            w_state_nxt     = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (frame_result == r_candidate) begin
            w_match_nxt = w_match_inc;
          end else if (frame_result == r_key_code) begin
            w_match_nxt = '0;
            w_state_nxt = w_stable_state;
          end else begin
            w_candidate_nxt = frame_result;
            w_match_nxt     = MATCH_ONE;
          end
        end
        default: begin
          w_match_nxt = '0;
          w_state_nxt = w_stable_state;
        end
      endcase

      if ((w_state_nxt == S_DEBOUNCE) && (w_match_nxt == MATCH_TARGET)) begin
        w_key_code_nxt    = w_candidate_nxt;
        w_key_valid_nxt   = (w_candidate_nxt != KEY_NONE);
        w_key_release_nxt = (w_candidate_nxt == KEY_NONE);
        w_match_nxt       = '0;
        w_state_nxt       = (w_candidate_nxt != KEY_NONE) ? S_HELD : S_IDLE;
      end
    end
  end

  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_release = r_key_release;

  a_debounce_min : assert property (@(posedge clk) disable iff (!rst) DEBOUNCE_SCANS >= 1);

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : keypad_matrix_scan                                     |
// | Description : Drives the four active-low column strobes of a 4x3     |
// |               keypad, synchronizes and samples the row returns, and  |
// |               reduces each full scan frame to its lowest button code |
// |               before handing it to the debouncer.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module keypad_matrix_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release
);

  localparam int                SLOT_W    = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [1:0]        COL_LAST  = 2'(NUM_COLS - 1);

  logic [2:0]        r_row_meta;
  logic [2:0]        r_row_sync;
  logic              r_running;
  logic [SLOT_W-1:0] r_slot_cnt;
  logic [1:0]        r_col_idx;
  logic [1:0]        w_col_next;
  logic [3:0]        r_col_n;
  logic [3:0]        r_frame_acc;
  logic [3:0]        w_col_code;
  logic [3:0]        w_merged;
  logic              w_sample;
  logic              w_frame_end;

  // Two-flop synchronizer for the asynchronous row returns (idle = all high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_meta <= 3'b111;
      r_row_sync <= 3'b111;
    end else begin
      r_row_meta <= row_n;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_sample    = r_running && (r_slot_cnt == SLOT_LAST);
  assign w_frame_end = w_sample && (r_col_idx == COL_LAST);
  assign w_col_next  = r_col_idx + 2'd1;

  // Slot/column counters and column drive; the first edge out of reset
  // starts column 0 so every column gets a full SCAN_DIV-cycle slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_running  <= 1'b0;
      r_slot_cnt <= '0;
      r_col_idx  <= 2'd0;
      r_col_n    <= 4'b1111;
    end else if (!r_running) begin
      r_running  <= 1'b1;
      r_slot_cnt <= '0;
      r_col_idx  <= 2'd0;
      r_col_n    <= 4'b1110;
    end else if (r_slot_cnt == SLOT_LAST) begin
      r_slot_cnt <= '0;
      r_col_idx  <= w_col_next;
      r_col_n    <= ~(4'b0001 << w_col_next);
    end else begin
      r_slot_cnt <= r_slot_cnt + SLOT_ONE;
    end
  end

  // Lowest pressed row in the driven column, then minimum against the frame so far.
  always_comb begin
    w_col_code = KEY_NONE;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!r_row_sync[r]) begin
        w_col_code = key_code_of(r_col_idx, 2'(r));
      end
    end
    w_merged = r_frame_acc;
    if ((w_col_code != KEY_NONE) &&
        ((r_frame_acc == KEY_NONE) || (w_col_code < r_frame_acc))) begin
      w_merged = w_col_code;
    end
  end

  // Frame accumulator; cleared in the same cycle the frame result is handed off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_acc <= KEY_NONE;
    end else if (w_sample) begin
      r_frame_acc <= w_frame_end ? KEY_NONE : w_merged;
    end
  end

  key_debounce #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_key_debounce (
    .clk          (clk),
    .rst          (rst),
    .frame_valid  (w_frame_end),
    .frame_result (w_merged),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .key_release  (key_release)
  );

  assign col_n = r_col_n;

  a_scan_div_min : assert property (@(posedge clk) disable iff (!rst) SCAN_DIV >= 4);

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_keypad_matrix_scan                                  |
// | Description : Self-checking bench: a behavioural keypad drives the   |
// |               rows from the column strobes; a frame-level model of   |
// |               the debounce rule predicts key_code and strobes.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_keypad_matrix_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_release;

  logic [12:1] pressed = '0;
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [3:0]  exp_code = 4'd0;
  logic [3:0]  hist[$];

  keypad_matrix_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // Physical keypad: button b sits at column (b-1)/3, row (b-1)%3.
  always_comb begin
    row_n = 3'b111;
    for (int b = 1; b <= 12; b++) begin
      if (pressed[b] && !col_n[(b - 1) / 3]) row_n[(b - 1) % 3] = 1'b0;
    end
  end

  function automatic logic [3:0] lowest(input logic [12:1] p);
    for (int b = 1; b <= 12; b++) if (p[b]) return 4'(b);
    return 4'd0;
  endfunction

  function automatic logic [3:0] col_at(input int j);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((j % FRAME) / SCAN_DIV));
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle(input string tag, input logic [3:0] ecol, input logic ev, input logic er);
    check({tag, ".col_n"}, col_n, ecol);
    check({tag, ".key_code"}, key_code, exp_code);
    check({tag, ".key_valid"}, {3'b000, key_valid}, {3'b000, ev});
    check({tag, ".key_release"}, {3'b000, key_release}, {3'b000, er});
  endtask

  // One full scan frame with the given buttons held; the model commits a new
  // stable key when the last DEB frame results agree and differ from it.
  task automatic run_frame(input string tag, input logic [12:1] p);
    logic [3:0] res;
    logic       ev;
    logic       er;
    logic       agree;
    @(negedge clk);
    pressed = p;
    for (int j = 1; j <= FRAME; j++) begin
      @(posedge clk);
      #1;
      ev = 1'b0;
      er = 1'b0;
      if (j == FRAME) begin
        res = lowest(p);
        hist.push_back(res);
        if (hist.size() > DEB) hist.delete(0);
        agree = (hist.size() == DEB);
        foreach (hist[k]) if (hist[k] != res) agree = 1'b0;
        if (agree && (res != exp_code)) begin
          exp_code = res;
          ev = (res != 4'd0);
          er = (res == 4'd0);
        end
      end
      check_cycle(tag, col_at(j), ev, er);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    #1;
    hist.delete();
    exp_code = 4'd0;
    check_cycle("in_reset", 4'b1111, 1'b0, 1'b0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_cycle("in_reset", 4'b1111, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cycle("first_edge", 4'b1110, 1'b0, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [12:1] p;
    int          n;
    p = '0;
    #2;
    do_reset(3);

    repeat (10) run_frame("idle", '0);

    repeat (5) run_frame("b5_hold", 12'b0000_0001_0000);
    repeat (3) run_frame("b5_release", '0);

    repeat (3) run_frame("b2_b12", 12'b1000_0000_0010);
    repeat (2) run_frame("b2_b12_rel", '0);

    repeat (3) begin
      run_frame("bounce_on", 12'b0000_0100_0000);
      run_frame("bounce_off", '0);
    end
    repeat (3) run_frame("b7_hold", 12'b0000_0100_0000);
    repeat (2) run_frame("b7_rel", '0);

    repeat (3) run_frame("b3_hold", 12'b0000_0000_0100);
    repeat (3) run_frame("b9_hold", 12'b0001_0000_0000);
    repeat (2) run_frame("b9_rel", '0);

    repeat (3) run_frame("b4_hold", 12'b0000_0000_1000);
    @(negedge clk);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk);
      #1;
      check_cycle("b4_midframe", col_at(j), 1'b0, 1'b0);
    end
    do_reset(2);
    repeat (4) run_frame("b4_after_rst", 12'b0000_0000_1000);
    repeat (2) run_frame("b4_rel", '0);

    repeat (24) begin
      if ($urandom_range(0, 1) == 1) begin
        p = '0;
        n = $urandom_range(0, 2);
        repeat (n) p[$urandom_range(1, 12)] = 1'b1;
      end
      run_frame("random", p);
    end
    repeat (3) run_frame("final_idle", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
